melody_sequencer: RTL

//  Parametrised score player for the clock's piezo buzzer. Steps through a score ROM one beat at a time
//  and drives a square-wave tone per note. Adds start/stop/pause control, one-shot or loop mode,
//  per-beat articulation gap and status outputs. Sits between the alarm/chime controller and the beep/sd pads.

---
 rtl/melody_pkg.sv | 31 +++
 rtl/melody_rom.sv | 18 +
 rtl/melody_sequencer.sv | 125 ++++++++++++
 3 files changed

// File: rtl/melody_pkg.sv
// Shared types and constants for the buzzer score player: note codes, the
// 50 MHz half-period table and the playback state encoding.
package melody_pkg;

  localparam int NOTE_W   = 5;
  localparam int NOTE_MAX = 21;
  localparam logic [NOTE_W-1:0] NOTE_REST = '0;

  typedef enum logic [1:0] {ST_IDLE, ST_PLAY, ST_PAUSE, ST_DONE} state_e;

  // Code 0 is rest; 1..7 low, 8..14 mid, 15..21 high octave (G-major scale from G3).
  localparam int unsigned HALF_PERIOD [0:NOTE_MAX] = '{
    0,
    127552, 113636, 101238, 95556, 85106, 75844, 67568,
    63776,  56818,  50619,  47778, 42553, 37922, 33784,
    31888,  28409,  25310,  23889, 21277, 18961, 16892
  };

  typedef logic [0:127][NOTE_W-1:0] score128_t;

  // Default score: ascending mid scale phrases separated by a rest.
  function automatic score128_t demo_score();
    score128_t s;
    for (int i = 0; i < 128; i++)
      s[i] = (i % 8 == 7) ? NOTE_REST : NOTE_W'(8 + (i % 8) % 7);
    return s;
  endfunction

  localparam score128_t DEFAULT_SCORE = demo_score();

endpackage

// File: rtl/melody_rom.sv
// Synchronous-read score ROM; the score is supplied as a parameter so the
// image travels with the instance rather than with an external file.
module melody_rom import melody_pkg::*; #(
  parameter int ADDR_W = 7,
  parameter logic [0:2**ADDR_W-1][NOTE_W-1:0] SCORE = '0
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [NOTE_W-1:0] code_o
);

  logic [NOTE_W-1:0] code_q;

  always_ff @(posedge clk) code_q <= SCORE[addr_i];

  assign code_o = code_q;

endmodule

// File: rtl/melody_sequencer.sv
// Score player: playback FSM, beat counter and square-wave tone divider
// driving the piezo buzzer and its amplifier enable.
module melody_sequencer import melody_pkg::*; #(
  parameter int BEAT_CYCLES = 25_000_000,
  parameter int GAP_CYCLES  = 1_250_000,
  parameter int SONG_LEN    = 114,
  parameter int ADDR_W      = 7,
  parameter int DIV_W       = 18,
  parameter int unsigned HP_TABLE [0:NOTE_MAX] = HALF_PERIOD,
  parameter logic [0:2**ADDR_W-1][NOTE_W-1:0] SCORE = DEFAULT_SCORE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic              loop_en,
  input  logic              gap_en,
  output logic              beep,
  output logic              sd,
  output logic              busy,
  output logic [ADDR_W-1:0] note_idx,
  output logic              beat_tick,
  output logic              done
);

  localparam int BW = $clog2(BEAT_CYCLES + 1);

  state_e            state_q, state_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DIV_W-1:0]  tone_q, tone_d, hp;
  logic              beep_q, beep_d, sd_q, sd_d;
  logic [NOTE_W-1:0] code;
  logic              adv, beat_end, last_beat, in_gap, active;

  melody_rom #(.ADDR_W(ADDR_W), .SCORE(SCORE)) u_rom (
    .clk    (clk),
    .addr_i (idx_q),
    .code_o (code)
  );

  // A beat only advances in PLAY when no control pulse is pending this cycle.
  assign adv       = (state_q == ST_PLAY) && !stop && !start && !pause;
  assign beat_end  = adv && (beat_q == BW'(BEAT_CYCLES - 1));
  assign last_beat = (idx_q == ADDR_W'(SONG_LEN - 1));

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    idx_d   = idx_q;
    if (stop) begin
      state_d = ST_IDLE;
      beat_d  = '0;
      idx_d   = '0;
    end else if (start) begin
      state_d = ST_PLAY;
      beat_d  = '0;
      idx_d   = '0;
    end else if (pause && state_q == ST_PLAY) begin
      state_d = ST_PAUSE;
    end else if (pause && state_q == ST_PAUSE) begin
      state_d = ST_PLAY;
    end else if (state_q == ST_PLAY) begin
      if (beat_end) begin
        beat_d = '0;
        if (!last_beat)   idx_d   = idx_q + ADDR_W'(1);
        else if (loop_en) idx_d   = '0;
        else              state_d = ST_DONE;
      end else begin
        beat_d = beat_q + BW'(1);
      end
    end
    sd_d = (state_d == ST_PLAY);
  end

  always_comb begin
    hp = '0;
    for (int k = 0; k <= NOTE_MAX; k++)
      if (code == NOTE_W'(k)) hp = DIV_W'(HP_TABLE[k]);
  end

  // Beat count 0 is the ROM-latency cycle: the code still belongs to the old beat.
  assign in_gap = gap_en && (beat_q >= BW'(BEAT_CYCLES - GAP_CYCLES));
  assign active = (state_q == ST_PLAY) && (beat_q != '0) && (hp != '0) && !in_gap;

  always_comb begin
    tone_d = '0;
    beep_d = 1'b0;
    if (active) begin
      if (tone_q == hp - DIV_W'(1)) begin
        beep_d = !beep_q;
      end else begin
        tone_d = tone_q + DIV_W'(1);
        beep_d = beep_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      idx_q   <= '0;
      tone_q  <= '0;
      beep_q  <= 1'b0;
      sd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      idx_q   <= idx_d;
      tone_q  <= tone_d;
      beep_q  <= beep_d;
      sd_q    <= sd_d;
    end
  end

  assign beep      = beep_q && active;
  assign sd        = sd_q;
  assign busy      = (state_q == ST_PLAY) || (state_q == ST_PAUSE);
  assign note_idx  = idx_q;
  assign beat_tick = beat_end;
  assign done      = beat_end && last_beat && !loop_en;

endmodule
